mem_lsu: RTL



---
 rtl/mem_lsu.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: issues one data-bus access at a time,
// steers store bytes onto lanes and formats load data for writeback.
//
// Bus handshake: bus_req_o is the valid; bus_ack_i / bus_err_i are the
// ready. The request and every bus_* qualifier are held stable from the
// first request cycle up to and including the cycle in which ack or err
// is seen. req drops in the following cycle. err wins over ack. ack or err
// outside an active request is ignored.
module mem_lsu #(
  parameter int TIMEOUT = 255,
  localparam int ADDR_WIDTH = 32,
  localparam int DATA_WIDTH = 32,
  localparam int RADDR_WIDTH = 5,
  localparam int RDATA_WIDTH = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [3:0]             mem_op_i,
  input  logic                   mem_we_i,
  input  logic [ADDR_WIDTH-1:0]  mem_addr_i,
  input  logic [DATA_WIDTH-1:0]  mem_data_i,
  input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
  input  logic                   reg_we_i,
  input  logic [RDATA_WIDTH-1:0] reg_wdata_i,
  output logic [RADDR_WIDTH-1:0] reg_waddr_o,
  output logic                   reg_we_o,
  output logic [RDATA_WIDTH-1:0] reg_wdata_o,
  output logic                   stallreq_o,
  output logic                   fault_o,
  output logic                   bus_req_o,
  output logic                   bus_we_o,
  output logic [ADDR_WIDTH-1:0]  bus_addr_o,
  output logic [3:0]             bus_be_o,
  output logic [DATA_WIDTH-1:0]  bus_wdata_o,
  input  logic                   bus_ack_i,
  input  logic [DATA_WIDTH-1:0]  bus_rdata_i,
  input  logic                   bus_err_i,
  output logic [1:0]             dbg_state_o
);

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LW  = 4'd3;
  localparam logic [3:0] OP_LBU = 4'd4;
  localparam logic [3:0] OP_LHU = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 2);
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [3:0]              r_op;
  logic [1:0]              r_lane;
  logic                    r_load;
  logic                    r_fault;
  logic [CW-1:0]           r_cnt;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic                    r_bus_we;
  logic [ADDR_WIDTH-1:0]   r_bus_addr;
  logic [3:0]              r_bus_be;
  logic [DATA_WIDTH-1:0]   r_bus_wdata;

  logic                    w_is_load;
  logic                    w_is_store;
  logic                    w_size_h;
  logic                    w_size_w;
  logic                    w_valid;
  logic                    w_misaligned;
  logic [3:0]              w_be;
  logic [DATA_WIDTH-1:0]   w_wdata;
  logic [7:0]              w_byte;
  logic [15:0]             w_half;
  logic [RDATA_WIDTH-1:0]  w_load_data;

  // Decode the request class and access size; unknown codes fall through as no-ops.
  always_comb begin
    w_is_load  = 1'b0;
    w_is_store = 1'b0;
    w_size_h   = 1'b0;
    w_size_w   = 1'b0;
    case (mem_op_i)
      OP_LB, OP_LBU: w_is_load = 1'b1;
      OP_LH, OP_LHU: begin w_is_load = 1'b1; w_size_h = 1'b1; end
      OP_LW:         begin w_is_load = 1'b1; w_size_w = 1'b1; end
      OP_SB:         w_is_store = 1'b1;
      OP_SH:         begin w_is_store = 1'b1; w_size_h = 1'b1; end
      OP_SW:         begin w_is_store = 1'b1; w_size_w = 1'b1; end
      default:       ;
    endcase
  end

  // A request whose write enable disagrees with its op is not issued.
  assign w_valid      = (w_is_load & ~mem_we_i) | (w_is_store & mem_we_i);
  assign w_misaligned = (w_size_h & mem_addr_i[0]) |
                        (w_size_w & (mem_addr_i[1:0] != 2'b00));

  // Store byte strobes and lane-replicated data; loads read the whole word.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = '0;
    if (w_is_store) begin
      if (w_size_w) begin
        w_be    = 4'b1111;
        w_wdata = mem_data_i;
      end else if (w_size_h) begin
        w_be    = 4'b0011 << {mem_addr_i[1], 1'b0};
        w_wdata = {2{mem_data_i[15:0]}};
      end else begin
        w_be    = 4'b0001 << mem_addr_i[1:0];
        w_wdata = {4{mem_data_i[7:0]}};
      end
    end
  end

  // Pick the addressed byte/half from the captured word and extend it.
  always_comb begin
    case (r_lane)
      2'd0:    w_byte = r_rdata[7:0];
      2'd1:    w_byte = r_rdata[15:8];
      2'd2:    w_byte = r_rdata[23:16];
      default: w_byte = r_rdata[31:24];
    endcase
    w_half = r_lane[1] ? r_rdata[31:16] : r_rdata[15:0];
    case (r_op)
      OP_LB:   w_load_data = {{24{w_byte[7]}}, w_byte};
      OP_LBU:  w_load_data = {24'b0, w_byte};
      OP_LH:   w_load_data = {{16{w_half[15]}}, w_half};
      OP_LHU:  w_load_data = {16'b0, w_half};
      default: w_load_data = r_rdata;
    endcase
  end

  // State register, access capture, timeout counter and fault flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_op        <= OP_NOP;
      r_lane      <= 2'b00;
      r_load      <= 1'b0;
      r_fault     <= 1'b0;
      r_cnt       <= '0;
      r_rdata     <= '0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= '0;
      r_bus_be    <= 4'b0000;
      r_bus_wdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (w_valid && !w_misaligned) begin
            r_op        <= mem_op_i;
            r_lane      <= mem_addr_i[1:0];
            r_load      <= w_is_load;
            r_fault     <= 1'b0;
            r_cnt       <= '0;
            r_bus_we    <= w_is_store;
            r_bus_addr  <= {mem_addr_i[ADDR_WIDTH-1:2], 2'b00};
            r_bus_be    <= w_be;
            r_bus_wdata <= w_wdata;
          end
        end
        S_BUS: begin
          r_cnt <= r_cnt + CW'(1);
          if (bus_err_i)              r_fault <= 1'b1;
          else if (bus_ack_i)         r_rdata <= bus_rdata_i;
          else if (r_cnt == TO_VAL)   r_fault <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Next state plus stall, fault and writeback outputs; all quiet during reset.
  always_comb begin
    w_state_nxt = r_state;
    stallreq_o  = 1'b0;
    fault_o     = 1'b0;
    bus_req_o   = 1'b0;
    reg_we_o    = 1'b0;
    reg_waddr_o = reg_waddr_i;
    reg_wdata_o = reg_wdata_i;
    if (rst_i) begin
      w_state_nxt = S_IDLE;
      reg_waddr_o = '0;
      reg_wdata_o = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_valid) begin
            reg_we_o = reg_we_i;
          end else if (w_misaligned) begin
            fault_o = 1'b1;
          end else begin
            stallreq_o  = 1'b1;
            w_state_nxt = S_BUS;
          end
        end
        S_BUS: begin
          stallreq_o = 1'b1;
          bus_req_o  = 1'b1;
          if (bus_err_i || bus_ack_i || (r_cnt == TO_VAL)) w_state_nxt = S_DONE;
        end
        S_DONE: begin
          fault_o     = r_fault;
          w_state_nxt = S_IDLE;
          if (r_load) begin
            reg_we_o    = reg_we_i & ~r_fault;
            reg_wdata_o = w_load_data;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign bus_we_o    = r_bus_we;
  assign bus_addr_o  = r_bus_addr;
  assign bus_be_o    = r_bus_be;
  assign bus_wdata_o = r_bus_wdata;
  assign dbg_state_o = r_state;

endmodule
